// File: rtl/game_result_tracker_pkg.sv
// rtl/game_result_tracker_pkg.sv - verdict codes, state encodings and LED patterns for game_result_tracker
package game_pkg;

    localparam logic [2:0] RES_NONE  = 3'b000;
    localparam logic [2:0] RES_WRONG = 3'b001;
    localparam logic [2:0] RES_OK    = 3'b010;

    typedef enum logic [2:0] {
        PLAY,
        SHOW_OK,
        SHOW_ERR,
        LOSE,
        WIN
    } state_e;

    localparam logic [2:0] LED_OFF = 3'b000;
    localparam logic [2:0] LED_OK  = 3'b010;
    localparam logic [2:0] LED_ERR = 3'b001;
    localparam logic [2:0] LED_ALL = 3'b111;

    // Increment a 4-bit counter, holding at 15.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/game_result_tracker_if.sv
// rtl/game_result_tracker_if.sv - input events and score/LED outputs of game_result_tracker
interface game_result_tracker_if;

    logic       submit;
    logic       level_adv;
    logic [2:0] result;
    logic [3:0] score;
    logic [1:0] strikes;
    logic [3:0] level;
    logic [2:0] led;
    logic       game_over;
    logic       win;
    logic [3:0] best_streak;

    modport master (
        output submit, level_adv, result,
        input  score, strikes, level, led, game_over, win, best_streak
    );

    modport slave (
        input  submit, level_adv, result,
        output score, strikes, level, led, game_over, win, best_streak
    );

endinterface

// File: rtl/game_result_tracker_blink_timer.sv
// rtl/game_result_tracker_blink_timer.sv - phase timer with expiry pulse and toggling phase bit
module blink_timer #(
    parameter int BLINK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire,
    output logic phase
);

    localparam int TW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(BLINK_CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Raw expiry; the owner decides whether a same-cycle restart overrides it.
    assign expire = (cnt_q == LAST);
    assign phase  = phase_q;

    // Next count wraps at the last cycle of a phase; phase flips on each wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else begin
            cnt_d   = expire ? '0 : cnt_q + 1'b1;
            phase_d = phase_q ^ expire;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/game_result_tracker.sv
// rtl/game_result_tracker.sv - score/strike/level tracker with LED feedback; GAME_STREAK_EN adds best-streak tracking
module game_result_tracker
    import game_pkg::*;
#(
    parameter int MAX_STRIKES  = 3,
    parameter int WIN_SCORE    = 10,
    parameter int NUM_LEVELS   = 10,
    parameter int BLINK_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    game_result_tracker_if.slave  bus
);

    localparam logic [1:0] MAX_S    = 2'(MAX_STRIKES);
    localparam logic [3:0] WIN_S    = 4'(WIN_SCORE);
    localparam logic [3:0] LAST_LVL = 4'(NUM_LEVELS - 1);

    state_e     state_q, state_d;
    logic [3:0] score_q, score_d;
    logic [1:0] strikes_q, strikes_d;
    logic [3:0] level_q, level_d;
    logic [2:0] led_q, led_d;
    logic       game_over_q, game_over_d;
    logic       win_q, win_d;
    logic       scored_q, scored_d;
    logic       sub_q, sub_d;
    logic       rise_q, rise_d;

    logic       in_term;
    logic       timer_restart;
    logic       timer_clear;
    logic       tmr_expire;
    logic       tmr_phase;
    logic       phase_nx;

    assign in_term = (state_q == LOSE) || (state_q == WIN);

    // Any counted verdict or level change restarts the feedback timer.
    assign timer_restart = ~in_term &
                           ((rise_q & ((bus.result == RES_OK) || (bus.result == RES_WRONG))) |
                            bus.level_adv);
    assign timer_clear   = timer_restart | (state_q == PLAY);

    blink_timer #(
        .BLINK_CYCLES (BLINK_CYCLES)
    ) u_blink_timer (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (timer_clear),
        .expire (tmr_expire),
        .phase  (tmr_phase)
    );

    // Verdict handling first, then level advance, then feedback timeout; LED follows the next state.
    always_comb begin
        sub_d       = bus.submit;
        rise_d      = bus.submit & ~sub_q;
        state_d     = state_q;
        score_d     = score_q;
        strikes_d   = strikes_q;
        level_d     = level_q;
        scored_d    = scored_q;
        led_d       = led_q;
        phase_nx    = timer_restart ? 1'b0 : (tmr_phase ^ tmr_expire);

        if (!in_term) begin
            if (rise_q) begin
                case (bus.result)
                    RES_OK: begin
                        state_d = SHOW_OK;
                        if (!scored_q) begin
                            score_d  = sat_inc4(score_q);
                            scored_d = 1'b1;
                            if (score_d == WIN_S) begin
                                state_d = WIN;
                            end
                        end
                    end
                    RES_WRONG: begin
                        strikes_d = (strikes_q == MAX_S) ? strikes_q : strikes_q + 2'd1;
                        state_d   = (strikes_d == MAX_S) ? LOSE : SHOW_ERR;
                    end
                    RES_NONE: begin
                    end
                    default: begin
                    end
                endcase
            end

            if (bus.level_adv) begin
                level_d  = (level_q == LAST_LVL) ? 4'd0 : level_q + 4'd1;
                scored_d = 1'b0;
                if (state_d != LOSE && state_d != WIN) begin
                    state_d = PLAY;
                end
            end

            if (!timer_restart && tmr_expire &&
                (state_q == SHOW_OK || state_q == SHOW_ERR)) begin
                state_d = PLAY;
            end
        end

        case (state_d)
            PLAY:     led_d = LED_OFF;
            SHOW_OK:  led_d = LED_OK;
            SHOW_ERR: led_d = LED_ERR;
            LOSE:     led_d = phase_nx ? LED_OFF : LED_ERR;
            WIN:      led_d = phase_nx ? LED_OFF : LED_ALL;
            default:  led_d = LED_OFF;
        endcase

        game_over_d = (state_d == LOSE);
        win_d       = (state_d == WIN);
    end

    // Game state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PLAY;
            score_q     <= 4'd0;
            strikes_q   <= 2'd0;
            level_q     <= 4'd0;
            led_q       <= LED_OFF;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            scored_q    <= 1'b0;
            sub_q       <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            strikes_q   <= strikes_d;
            level_q     <= level_d;
            led_q       <= led_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
            scored_q    <= scored_d;
            sub_q       <= sub_d;
            rise_q      <= rise_d;
        end
    end

    assign bus.score     = score_q;
    assign bus.strikes   = strikes_q;
    assign bus.level     = level_q;
    assign bus.led       = led_q;
    assign bus.game_over = game_over_q;
    assign bus.win       = win_q;

`ifdef GAME_STREAK_EN
    logic [3:0] run_q, run_d;
    logic [3:0] best_q, best_d;
    logic       streak_hit;
    logic       streak_miss;

    assign streak_hit  = ~in_term & rise_q & (bus.result == RES_OK) & ~scored_q;
    assign streak_miss = ~in_term & rise_q & (bus.result == RES_WRONG);

    // Current run of counted correct verdicts and the longest run seen.
    always_comb begin
        run_d = run_q;
        if (streak_miss) begin
            run_d = 4'd0;
        end else if (streak_hit) begin
            run_d = sat_inc4(run_q);
        end
        best_d = (run_d > best_q) ? run_d : best_q;
    end

    // Streak registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q  <= 4'd0;
            best_q <= 4'd0;
        end else begin
            run_q  <= run_d;
            best_q <= best_d;
        end
    end

    assign bus.best_streak = best_q;
`else
    assign bus.best_streak = 4'd0;
`endif

endmodule

// File: tb/tb_game_result_tracker.sv
// tb/tb_game_result_tracker.sv - randomized and directed bench for game_result_tracker
module tb_game_result_tracker;

    localparam int N  = 4;
    localparam int MS = 3;
    localparam int WS = 10;
    localparam int NL = 10;

    localparam int M_PLAY = 0;
    localparam int M_OK   = 1;
    localparam int M_ERR  = 2;
    localparam int M_LOSE = 3;
    localparam int M_WIN  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    game_result_tracker_if bus();

    game_result_tracker #(
        .MAX_STRIKES  (MS),
        .WIN_SCORE    (WS),
        .NUM_LEVELS   (NL),
        .BLINK_CYCLES (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain game rules
    int m_score, m_strikes, m_level, m_mode, m_age, m_run, m_best;
    bit m_scored, m_sub_prev, m_rise;

    logic [18:0] dut_vec;
    assign dut_vec = {bus.score, bus.strikes, bus.level, bus.led,
                      bus.game_over, bus.win, bus.best_streak};

    function automatic logic [2:0] exp_led();
        case (m_mode)
            M_OK:    return 3'b010;
            M_ERR:   return 3'b001;
            M_LOSE:  return ((m_age / N) % 2 == 0) ? 3'b001 : 3'b000;
            M_WIN:   return ((m_age / N) % 2 == 0) ? 3'b111 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [18:0] exp_vec();
        int b;
`ifdef GAME_STREAK_EN
        b = m_best;
`else
        b = 0;
`endif
        return {4'(m_score), 2'(m_strikes), 4'(m_level), exp_led(),
                (m_mode == M_LOSE), (m_mode == M_WIN), 4'(b)};
    endfunction

    task automatic model_reset();
        m_score = 0; m_strikes = 0; m_level = 0; m_mode = M_PLAY; m_age = 0;
        m_run = 0; m_best = 0; m_scored = 0; m_sub_prev = 0; m_rise = 0;
    endtask

    task automatic model_edge();
        bit ev;
        bit entered;
        int res;
        ev      = m_rise;
        entered = 0;
        res     = int'(bus.result);
        m_rise     = bus.submit && !m_sub_prev;
        m_sub_prev = bus.submit;
        if (m_mode == M_LOSE || m_mode == M_WIN) begin
            m_age++;
            return;
        end
        if (ev && res == 2) begin
            if (!m_scored) begin
                if (m_score < 15) m_score++;
                m_scored = 1;
                if (m_run < 15) m_run++;
                if (m_run > m_best) m_best = m_run;
                m_mode = (m_score == WS) ? M_WIN : M_OK;
            end else begin
                m_mode = M_OK;
            end
            entered = 1;
        end else if (ev && res == 1) begin
            if (m_strikes < MS) m_strikes++;
            m_run   = 0;
            m_mode  = (m_strikes == MS) ? M_LOSE : M_ERR;
            entered = 1;
        end
        if (bus.level_adv) begin
            m_level  = (m_level + 1) % NL;
            m_scored = 0;
            if (m_mode != M_LOSE && m_mode != M_WIN) m_mode = M_PLAY;
            entered = 1;
        end
        if (entered) begin
            m_age = 0;
        end else begin
            m_age++;
            if ((m_mode == M_OK || m_mode == M_ERR) && m_age == N) m_mode = M_PLAY;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic submit_pulse(input logic [2:0] res, input logic adv);
        bus.result = res;
        bus.submit = 1'b1;
        step();
        bus.submit    = 1'b0;
        bus.level_adv = adv;
        step();
        bus.level_adv = 1'b0;
    endtask

    task automatic apply_reset();
        bus.submit = 1'b0; bus.level_adv = 1'b0; bus.result = 3'b000;
        #1 reset = 1'b0;
        model_reset();
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.submit = 1'b0; bus.level_adv = 1'b0; bus.result = 3'b000;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if (dut_vec !== 19'd0) begin
            n_errors++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_errors++; $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_ok_hold();
        int led_on = 0;
        bus.result = 3'b010;
        bus.submit = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 10) bus.submit = 1'b0;
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_errors++; $display("FAIL ok_hold_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (bus.led === 3'b010) led_on++;
        end
        n_checks++;
        if (bus.score !== 4'd1) begin
            n_errors++; $display("FAIL ok_hold_score: got %0d want 1", bus.score);
        end
        n_checks++;
        if (led_on != N) begin
            n_errors++; $display("FAIL ok_hold_led_len: got %0d want %0d", led_on, N);
        end
        submit_pulse(3'b010, 1'b0);
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (bus.score !== 4'd1) begin
            n_errors++; $display("FAIL ok_same_level: got %0d want 1", bus.score);
        end
    endtask

    task automatic test_reset_mid_show();
        submit_pulse(3'b010, 1'b0);
        n_checks++;
        if (bus.led !== 3'b010) begin
            n_errors++; $display("FAIL mid_show_led: got %b want 010", bus.led);
        end
        #1 reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== 19'd0) begin
            n_errors++; $display("FAIL async_reset: got %h want 0", dut_vec);
        end
        #1 reset = 1'b1;
        step();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_errors++; $display("FAIL after_reset_play: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_lose();
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            submit_pulse(3'b001, 1'b0);
            n_checks++;
            if (bus.strikes !== 2'(k) || bus.game_over !== (k == 3)) begin
                n_errors++; $display("FAIL lose_strike%0d: got strikes=%0d go=%b", k, bus.strikes, bus.game_over);
            end
            if (k < 3) for (int i = 0; i < 5; i++) step();
        end
        n_checks++;
        if (bus.led !== 3'b001) begin
            n_errors++; $display("FAIL lose_led_entry: got %b want 001", bus.led);
        end
        for (int i = 1; i <= 12; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_errors++; $display("FAIL lose_blink%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 4 || i == 8) begin
                n_checks++;
                if (bus.led !== ((i == 4) ? 3'b000 : 3'b001)) begin
                    n_errors++; $display("FAIL lose_led_phase%0d: got %b", i, bus.led);
                end
            end
        end
        bus.level_adv = 1'b1; step(); bus.level_adv = 1'b0;
        submit_pulse(3'b010, 1'b0);
        n_checks++;
        if (bus.level !== 4'd0 || bus.score !== 4'd0 || bus.game_over !== 1'b1) begin
            n_errors++; $display("FAIL lose_absorbing: got level=%0d score=%0d go=%b", bus.level, bus.score, bus.game_over);
        end
    endtask

    task automatic test_win_wrap();
        apply_reset();
        for (int r = 0; r < 9; r++) begin
            n_checks++;
            if (bus.level !== 4'(r)) begin
                n_errors++; $display("FAIL win_level%0d: got %0d", r, bus.level);
            end
            submit_pulse(3'b010, 1'b0);
            for (int i = 0; i < 5; i++) step();
            bus.level_adv = 1'b1; step(); bus.level_adv = 1'b0;
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_errors++; $display("FAIL win_round%0d: got %h want %h", r, dut_vec, exp_vec());
            end
        end
        submit_pulse(3'b010, 1'b1);
        n_checks++;
        if (bus.win !== 1'b1 || bus.score !== 4'd10 || bus.level !== 4'd0 || bus.led !== 3'b111) begin
            n_errors++; $display("FAIL win_entry: got win=%b score=%0d level=%0d led=%b", bus.win, bus.score, bus.level, bus.led);
        end
        for (int i = 1; i <= 9; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_errors++; $display("FAIL win_blink%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            bus.level_adv = 1'b1; step(); bus.level_adv = 1'b0; step();
        end
        submit_pulse(3'b010, 1'b1);
        n_checks++;
        if (bus.score !== 4'd1 || bus.level !== 4'd0) begin
            n_errors++; $display("FAIL same_cycle: got score=%0d level=%0d want 1/0", bus.score, bus.level);
        end
        step(); step();
        submit_pulse(3'b010, 1'b0);
        n_checks++;
        if (bus.score !== 4'd2) begin
            n_errors++; $display("FAIL same_cycle_next: got %0d want 2", bus.score);
        end
    endtask

    task automatic test_streak();
        logic [3:0] want;
        apply_reset();
        submit_pulse(3'b010, 1'b1);
        submit_pulse(3'b010, 1'b1);
        submit_pulse(3'b001, 1'b1);
        submit_pulse(3'b010, 1'b1);
`ifdef GAME_STREAK_EN
        want = 4'd2;
`else
        want = 4'd0;
`endif
        n_checks++;
        if (bus.best_streak !== want || bus.score !== 4'd3 || bus.strikes !== 2'd1) begin
            n_errors++; $display("FAIL streak: got best=%0d score=%0d strikes=%0d want best=%0d", bus.best_streak, bus.score, bus.strikes, want);
        end
    endtask

    task automatic test_random();
        bit prev_adv = 0;
        int r;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            if ($urandom_range(0, 2) == 0) bus.submit = ~bus.submit;
            bus.level_adv = !prev_adv && ($urandom_range(0, 7) == 0);
            prev_adv = bus.level_adv;
            r = $urandom_range(0, 99);
            bus.result = (r < 60) ? 3'b010 : (r < 72) ? 3'b001 : 3'($urandom_range(0, 7));
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_errors++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        bus.submit = 1'b0; bus.level_adv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ok_hold();
        test_reset_mid_show();
        test_lose();
        test_win_wrap();
        test_same_cycle();
        test_streak();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
